mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle MIPS core's memory interface: accepts word/byte read and write requests carrying the controller's MemWrite and MemMode encodings and returns data after a programmable wait. It holds a unified instruction/data array, performs big-endian byte-lane selection with sign or zero extension, and implements byte stores as read-modify-write. It replaces the combinational memory model so that a stalling controller can run against realistic memory latency.

## Interface
- ADDR_W, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- WAIT, 1: extra wait cycles per access, range 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- MemWrite  in  1  1 = store, 0 = load.
- MemMode  in  2  access mode: 00 = word, 01 = signed byte, 10 = unsigned byte, 11 = reserved.
- addr  in  32  byte address.
- wdata  in  32  store data; byte stores use wdata[7:0].
- rdata  out  32  load result; updated only at DONE.
- ready  out  1  high for exactly one cycle in DONE.
- busy  out  1  high whenever state != IDLE.
- err  out  1  error status of the completing request; meaningful only while ready is high.

## Operation
- States: IDLE, WAIT, ACCESS, MODIFY, DONE.
- **IDLE**
  - On req=1, latch MemWrite, MemMode, addr and wdata. Later changes on the input pins have no effect on the accepted request.
  - Error check: the request errs if MemMode=11, if MemMode=00 and addr[1:0]!=0, or if addr[31:ADDR_W+2]!=0.
  - Next state: DONE with err=1 if the request errs; otherwise WAIT with cnt=WAIT when WAIT>0, else ACCESS.
- **WAIT**
  - Decrement cnt each cycle.
  - Move to ACCESS in the cycle where cnt==1.
- **ACCESS**
  - Read the word at addr[ADDR_W+1:2] into buf.
  - Word store: write wdata to the array; next state DONE.
  - Word load: rdata_next = buf; next state DONE.
  - Byte lanes are big-endian: offset 0 -> buf[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Byte load: selected lane, sign-extended for mode 01, zero-extended for mode 10; next state DONE.
  - Byte store: next state MODIFY.
- **MODIFY**
  - Write buf with the selected lane replaced by wdata[7:0]; the other three lanes are unchanged.
  - Next state DONE.
- **DONE**
  - ready=1, and err reflects the request.
  - rdata is loaded for successful loads only. Stores and errored requests leave rdata unchanged.
  - Always return to IDLE. A req asserted in DONE is ignored.
- A req asserted while busy=1 is ignored and never queued.
- Errored requests never modify the array or rdata.

## Timing
- Request sampled at the end of cycle T.
- Load or word store: DONE (ready high) in cycle T+WAIT+2.
- Byte store: DONE in cycle T+WAIT+3.
- Errored request: DONE in cycle T+1.
- Earliest next acceptance is the cycle after DONE. Best-case throughput with WAIT=0 is one load every 3 cycles.
- Array writes commit at the rising edge that ends ACCESS (word store) or MODIFY (byte store).
- rdata holds its value from DONE until the next successful load's DONE.
- Reset values: state=IDLE, cnt=0, rdata=0, ready=0, busy=0, err=0. Array contents are not cleared by reset.
- Reset mid-operation:
  - The request is abandoned and no ready is produced.
  - A store whose commit edge has not yet occurred (still in WAIT or ACCESS, or in MODIFY for a byte store) leaves the array unchanged.
  - The first req after reset deasserts is sampled normally.
- Reset asserted together with req: reset wins and the request is dropped.
- WAIT=0: the WAIT state is never entered.

## Test plan
- WAIT=1: preload word 4 = 0x8899AABB. Word load at addr 0x10 -> ready in cycle T+3, rdata=0x8899AABB, err=0.
- Signed byte load at 0x11 -> rdata=0xFFFFFF99. Unsigned byte load at 0x11 -> 0x00000099. Signed byte load at 0x13 -> 0xFFFFFFBB.
- Byte store of 0x5A at 0x12 -> ready at T+4, err=0. Word load at 0x10 then returns 0x88995ABB.
- Error cases: word load at 0x0E -> ready at T+1 with err=1 and rdata unchanged. Mode 11 -> err=1. Address 0x00001000 with ADDR_W=10 -> err=1. In every case the array is unchanged.
- req pulsed every cycle during a load -> exactly one ready. busy stays high from T+1 through DONE, and the interleaved pulses produce no extra accesses.
- Reset asserted during MODIFY of a byte store to 0x10 -> outputs return to reset values, no ready is produced, and word 4 remains 0x8899AABB.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS core: word/byte loads and stores
// with a programmable wait, big-endian lanes, and byte stores done as read-modify-write.
module mem_responder #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        MemWrite,
   input  logic [1:0]  MemMode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_MODIFY,
      S_DONE
   } state_t;

   state_t             state, state_nx;
   logic [3:0]         cnt, cnt_nx;
   logic               err_q, err_nx;

   logic               we_q;
   logic [1:0]         mode_q;
   logic [ADDR_W+1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        buf_q;

   logic [31:0]        mem [2**ADDR_W];

   logic [ADDR_W-1:0]  widx;
   logic [1:0]         off;
   logic [31:0]        rd_word;
   logic [31:0]        ld_val;
   logic               req_err;
   logic               load_en;
   logic               wr_en;
   logic [31:0]        wr_data;

   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] o);
      logic [7:0] b;
      case (o)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [31:0] byte_ext(input logic [7:0] b, input logic sgn);
      logic signed [7:0] b_s;
      b_s = b;
      return sgn ? 32'(b_s) : {24'd0, b};
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] o,
                                              input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (o)
         2'd0:    w[31:24] = b;
         2'd1:    w[23:16] = b;
         2'd2:    w[15:8]  = b;
         default: w[7:0]   = b;
      endcase
      return w;
   endfunction

   // Request decode and error screening on the raw pins (only used in IDLE)
   assign req_err = (MemMode == 2'b11) ||
                    ((MemMode == 2'b00) && (addr[1:0] != 2'b00)) ||
                    ((addr >> (ADDR_W + 2)) != 32'd0);

   assign widx    = addr_q[ADDR_W+1:2];
   assign off     = addr_q[1:0];
   assign rd_word = mem[widx];
   assign ld_val  = (mode_q == 2'b00) ? rd_word
                                      : byte_ext(lane_sel(rd_word, off), mode_q == 2'b01);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = err_q;
      load_en  = 1'b0;
      wr_en    = 1'b0;
      wr_data  = wdata_q;
      case (state)
         S_IDLE: begin
            if (req) begin
               err_nx = req_err;
               if (req_err) begin
                  state_nx = S_DONE;
               end else if (WAIT > 0) begin
                  state_nx = S_WAIT;
                  cnt_nx   = 4'(WAIT);
               end else begin
                  state_nx = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt <= 4'd1) state_nx = S_ACCESS;
         end
         S_ACCESS: begin
            if (we_q) begin
               if (mode_q == 2'b00) begin
                  wr_en    = 1'b1;
                  wr_data  = wdata_q;
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_MODIFY;
               end
            end else begin
               load_en  = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_MODIFY: begin
            wr_en    = 1'b1;
            wr_data  = lane_merge(buf_q, off, wdata_q[7:0]);
            state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Control state: reset applies here only
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         err_q <= 1'b0;
         rdata <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err_q <= err_nx;
         if (load_en) rdata <= ld_val;
      end
   end

   // Request capture and RMW buffer: data path, not reset
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req) begin
         we_q    <= MemWrite;
         mode_q  <= MemMode;
         addr_q  <= addr[ADDR_W+1:0];
         wdata_q <= wdata;
      end
      if (state == S_ACCESS) buf_q <= rd_word;
   end

   // Array commit; a reset on the commit edge abandons the store
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[widx] <= wr_data;
   end

   assign ready = (state == S_DONE);
   assign busy  = (state != S_IDLE);
   assign err   = ready & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed test-plan steps followed by
// random traffic, all checked against a word-array reference model.
module tb_mem_responder;
   localparam int ADDR_W = 10;
   localparam int WAIT   = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        MemWrite;
   logic [1:0]  MemMode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   int unsigned mem_m [int unsigned];
   logic [31:0] rdata_m;

   mem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
      .clk(clk), .reset(reset), .req(req), .MemWrite(MemWrite), .MemMode(MemMode),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: error rule, expected latency, and array/rdata effect of one request
   task automatic model_apply(input logic we, input logic [1:0] mode, input logic [31:0] a,
                              input logic [31:0] d, output bit e, output int lat);
      int unsigned w, idx, sh, b;
      e = (mode == 2'd3) || (mode == 2'd0 && (a % 4) != 0) || (a >= (32'd4 << ADDR_W));
      lat = 1;
      if (!e) begin
         idx = a / 4;
         sh  = 8 * (3 - (a % 4));
         w   = mem_m.exists(idx) ? mem_m[idx] : 0;
         if (we) begin
            if (mode == 2'd0) begin
               mem_m[idx] = d;
               lat = WAIT + 2;
            end else begin
               mem_m[idx] = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
               lat = WAIT + 3;
            end
         end else begin
            lat = WAIT + 2;
            if (mode == 2'd0) begin
               rdata_m = w;
            end else begin
               b = (w >> sh) & 32'hFF;
               if (mode == 2'd1 && b >= 128) b = b + 32'hFFFFFF00;
               rdata_m = b;
            end
         end
      end
   endtask

   task automatic do_op(input string tag, input logic we, input logic [1:0] mode,
                        input logic [31:0] a, input logic [31:0] d, input bit spam);
      bit e;
      int lat, exp_lat;
      model_apply(we, mode, a, d, e, exp_lat);
      @(negedge clk);
      req = 1'b1; MemWrite = we; MemMode = mode; addr = a; wdata = d;
      @(posedge clk);
      #1;
      if (!spam) req = 1'b0;
      MemWrite = 1'b1; MemMode = 2'b00; addr = 32'h40; wdata = $urandom;
      lat = 1;
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      while (!ready && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      req = 1'b0;
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".err"}, 32'(err), 32'(e));
      chk({tag, ".rdata"}, rdata, rdata_m);
      @(posedge clk);
      #1;
      chk({tag, ".idle"}, 32'({ready, busy}), 32'd0);
   endtask

   initial begin
      logic        rwe;
      logic [1:0]  rmode;
      logic [31:0] ra;
      int unsigned rsel, ridx;

      reset = 1'b1; req = 1'b0; MemWrite = 1'b0; MemMode = 2'b00;
      addr = 32'd0; wdata = 32'd0; rdata_m = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rdata", rdata, 32'd0);
      chk("reset.flags", 32'({ready, busy, err}), 32'd0);
      reset = 1'b0;

      do_op("pre16", 1'b1, 2'd0, 32'h40, 32'h13572468, 1'b0);
      do_op("pre4", 1'b1, 2'd0, 32'h10, 32'h8899AABB, 1'b0);
      for (int i = 0; i < 8; i++)
         if (i != 4) do_op("init", 1'b1, 2'd0, 32'(i * 4), $urandom, 1'b0);

      do_op("lw10", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0);
      chk("tp.lw10", rdata, 32'h8899AABB);
      do_op("lb11", 1'b0, 2'd1, 32'h11, 32'd0, 1'b0);
      chk("tp.lb11", rdata, 32'hFFFFFF99);
      do_op("lbu11", 1'b0, 2'd2, 32'h11, 32'd0, 1'b0);
      chk("tp.lbu11", rdata, 32'h00000099);
      do_op("lb13", 1'b0, 2'd1, 32'h13, 32'd0, 1'b0);
      chk("tp.lb13", rdata, 32'hFFFFFFBB);
      do_op("sb12", 1'b1, 2'd1, 32'h12, 32'h0000005A, 1'b0);
      do_op("lw10b", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0);
      chk("tp.rmw", rdata, 32'h88995ABB);
      do_op("restore", 1'b1, 2'd0, 32'h10, 32'h8899AABB, 1'b0);

      do_op("e.lwmis", 1'b0, 2'd0, 32'h0E, 32'd0, 1'b0);
      do_op("e.mode3", 1'b0, 2'd3, 32'h10, 32'd0, 1'b0);
      do_op("e.range", 1'b0, 2'd0, 32'h00001000, 32'd0, 1'b0);
      do_op("e.swmis", 1'b1, 2'd0, 32'h12, 32'hDEADBEEF, 1'b0);
      do_op("e.sbrng", 1'b1, 2'd2, 32'h00001010, 32'h000000EE, 1'b0);
      do_op("e.sm3", 1'b1, 2'd3, 32'h10, 32'hCAFEF00D, 1'b0);
      do_op("e.chk", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0);
      chk("tp.errarr", rdata, 32'h8899AABB);

      do_op("spam", 1'b0, 2'd0, 32'h10, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("spam.noready", 32'({ready, busy}), 32'd0);
      end
      do_op("spam.w16", 1'b0, 2'd0, 32'h40, 32'd0, 1'b0);

      // Reset during the MODIFY cycle of a byte store
      @(negedge clk);
      req = 1'b1; MemWrite = 1'b1; MemMode = 2'b10; addr = 32'h10; wdata = 32'h000000A5;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (WAIT + 1) @(posedge clk);
      #1;
      chk("rstmod.pre", 32'({ready, busy}), 32'b01);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rdata_m = 32'd0;
      chk("rstmod.flags", 32'({ready, busy, err}), 32'd0);
      chk("rstmod.rdata", rdata, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rstmod.noready", 32'(ready), 32'd0);
      end
      do_op("rstmod.lw", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0);
      chk("tp.rstmod", rdata, 32'h8899AABB);

      // Reset and req together: request dropped
      @(negedge clk);
      reset = 1'b1; req = 1'b1; MemWrite = 1'b1; MemMode = 2'b00;
      addr = 32'h10; wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      reset = 1'b0; req = 1'b0;
      rdata_m = 32'd0;
      chk("rstreq.busy", 32'(busy), 32'd0);
      do_op("rstreq.lw", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         rsel  = $urandom_range(0, 9);
         rwe   = 1'($urandom_range(0, 1));
         rmode = 2'($urandom_range(0, 2));
         ridx  = $urandom_range(0, 7);
         ra    = 32'(ridx * 4 + ((rmode == 2'd0) ? 0 : $urandom_range(0, 3)));
         if (rsel == 0) rmode = 2'd3;
         if (rsel == 1) ra = ra | (32'd1 << $urandom_range(12, 31));
         if (rsel == 2) begin
            rmode = 2'd0;
            ra = 32'(ridx * 4 + $urandom_range(1, 3));
         end
         do_op("rand", rwe, rmode, ra, $urandom, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
